two_ch_trig_capture: RTL
========================

# two_ch_trig_capture

Dual-channel triggered capture buffer directly downstream of the two-channel ADC capture/sync stage. It takes the SYS_CLK-domain 14-bit sample streams of channel A and channel B, holds them in a circular on-chip buffer, and detects a level/slope trigger on channel A or a forced trigger. It freezes a pre/post-trigger window of exactly 2^DEPTH_LOG2 sample pairs and streams that window out in time order through a request/valid read port for the acquisition readout logic.

## Interface
- DEPTH_LOG2, 10, log2 of buffer depth; DEPTH = 2^DEPTH_LOG2 sample pairs.
- SYS_CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- A2DA_DATA  in  14  channel A sample, unsigned, new sample every cycle.
- A2DB_DATA  in  14  channel B sample, unsigned, new sample every cycle.
- ARM  in  1  start a capture; sampled only in IDLE.
- TRIG_LEVEL  in  14  unsigned trigger threshold on channel A.
- TRIG_SLOPE  in  1  0 = rising, 1 = falling.
- FORCE_TRIG  in  1  immediate trigger while waiting.
- PRE_SAMPLES  in  DEPTH_LOG2  pre-trigger samples; latched on ARM.
- RD_REQ  in  1  read one word; honoured only in READ.
- RD_DATA  out  28  {A[13:0], B[13:0]}.
- RD_VALID  out  1  RD_DATA valid this cycle.
- RD_LAST  out  1  with RD_VALID, marks final word of window.
- STATE  out  3  IDLE=0, PRE=1, WAIT=2, POST=3, READ=4.
- TRIG_ADDR  out  DEPTH_LOG2  buffer address of the trigger sample.

## Operation
- Buffer: DEPTH x 28 bit simple dual-port RAM, registered read. Write pointer wp increments mod DEPTH on every write.
- prevA register loads A2DA_DATA every cycle in every state. It resets to 0.
- Rising trigger: prevA < TRIG_LEVEL and A2DA_DATA >= TRIG_LEVEL. Falling trigger: prevA >= TRIG_LEVEL and A2DA_DATA < TRIG_LEVEL. Both compares are unsigned.
- IDLE: no writes. On ARM, latch PRE_SAMPLES into pre_q, set wp=0 and cnt=0. Go to PRE, or to WAIT if PRE_SAMPLES = 0.
- PRE: write the current pair, cnt++. When cnt reaches pre_q, go to WAIT. Triggers are ignored in PRE.
- WAIT: write the current pair every cycle, with circular overwrite. On trigger or FORCE_TRIG in the same cycle, the current pair is the trigger sample. Latch TRIG_ADDR = wp and post = DEPTH-1-pre_q. Go to POST, or to READ if post = 0.
- POST: write the current pair, post--. After the write at post = 1, go to READ.
- READ: read start address rs = TRIG_ADDR - pre_q (mod DEPTH). Each accepted RD_REQ reads address rs+k for k = 0..DEPTH-1. The word at k = 0 is the oldest sample.
  - Once DEPTH requests have been accepted, further RD_REQ is ignored.
  - When the word with RD_LAST is presented, return to IDLE.
- RESET in any state: go to IDLE, clear wp/cnt/post/prevA/TRIG_ADDR, drop RD_VALID/RD_LAST. RAM contents are not cleared.
- ARM outside IDLE is ignored. FORCE_TRIG outside WAIT is ignored.

## Timing
- Reset values: STATE=0, RD_DATA=0, RD_VALID=0, RD_LAST=0, TRIG_ADDR=0.
- Trigger latency: zero. The pair present on the trigger cycle is written at TRIG_ADDR. STATE shows POST on the next cycle.
- Capture length after ARM: pre_q cycles in PRE, ≥1 cycle in WAIT, then DEPTH-1-pre_q cycles in POST. The window always holds exactly DEPTH pairs, and the trigger sample sits at index pre_q.
- Read latency: RD_REQ accepted in cycle n gives RD_VALID and RD_DATA in cycle n+1. Back-to-back requests give one word per cycle.
- RD_LAST is asserted with the DEPTH-th word. STATE = IDLE in the cycle after RD_LAST.
- RD_DATA holds its last value when RD_VALID = 0.

## Test plan
- DEPTH_LOG2=4, PRE_SAMPLES=4, rising, TRIG_LEVEL=100, A ramp 0,1,2,… from the ARM cycle, B = A+1000 -> TRIG_ADDR=(trigger address); readout gives 16 words A=96..111, B=1096..1111; RD_LAST on A=111.
- Same setup, falling, TRIG_LEVEL=50, A ramp down from 200 -> trigger on A=49; readout A=53..38; STATE sequence 1,2,3,4,0.
- PRE_SAMPLES=0, FORCE_TRIG on the first WAIT cycle with A=7 -> PRE skipped; first read word A=7; 16 words total.
- PRE_SAMPLES=15, level never crossed for 40 cycles, then crossing -> no POST cycles (READ the cycle after trigger); last word is the trigger sample.
- RD_REQ toggled 1,0,1,0 in READ -> RD_VALID follows one cycle later; extra RD_REQ after 16 accepted is ignored; ARM during POST is ignored.
- RESET asserted mid-POST -> next cycle STATE=0, RD_VALID=0, TRIG_ADDR=0; fresh ARM captures correctly.

Source files
------------

// File: rtl/two_ch_trig_capture.sv
// Dual-channel circular capture buffer: freezes a pre/post-trigger window of DEPTH pairs and reads it out oldest-first.
// Latency: trigger sample written on the trigger cycle; RD_DATA/RD_VALID one cycle after an accepted RD_REQ.
// Backpressure: none on the sample inputs (one pair per cycle); readout is paced by RD_REQ, one word per request.
module two_ch_trig_capture #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  SYS_CLK,
    input  logic                  RESET,
    input  logic [13:0]           A2DA_DATA,
    input  logic [13:0]           A2DB_DATA,
    input  logic                  ARM,
    input  logic [13:0]           TRIG_LEVEL,
    input  logic                  TRIG_SLOPE,
    input  logic                  FORCE_TRIG,
    input  logic [DEPTH_LOG2-1:0] PRE_SAMPLES,
    input  logic                  RD_REQ,
    output logic [27:0]           RD_DATA,
    output logic                  RD_VALID,
    output logic                  RD_LAST,
    output logic [2:0]            STATE,
    output logic [DEPTH_LOG2-1:0] TRIG_ADDR
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_READ = 3'd4;

    // Index of the final word of the window in the read counter.
    localparam logic [DEPTH_LOG2:0] LAST_IDX = (DEPTH_LOG2 + 1)'(DEPTH - 1);

    typedef logic [DEPTH_LOG2-1:0] addr_t;

    logic [27:0]       mem [DEPTH];
    logic [2:0]        state;
    addr_t             pre_q;
    addr_t             wp;
    addr_t             cnt;
    addr_t             post;
    logic [13:0]       prev_a;
    logic [DEPTH_LOG2:0] rd_cnt;   // one extra bit so "all DEPTH accepted" is representable

    logic  wr_en;
    logic  trig_hit;
    logic  rd_accept;
    addr_t cnt_nxt;
    addr_t post_init;
    addr_t rd_start;
    addr_t rd_addr;

    // Trigger detection, write enable and read address generation.
    always_comb begin
        wr_en     = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
        trig_hit  = TRIG_SLOPE ? ((prev_a >= TRIG_LEVEL) && (A2DA_DATA <  TRIG_LEVEL))
                               : ((prev_a <  TRIG_LEVEL) && (A2DA_DATA >= TRIG_LEVEL));
        cnt_nxt   = cnt + addr_t'(1);
        post_init = '1 - pre_q;
        rd_start  = TRIG_ADDR - pre_q;
        rd_addr   = rd_start + rd_cnt[DEPTH_LOG2-1:0];
        rd_accept = (state == S_READ) && RD_REQ && !rd_cnt[DEPTH_LOG2];
    end

    // Previous channel A sample for slope detection, tracked in every state.
    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            prev_a <= '0;
        end else begin
            prev_a <= A2DA_DATA;
        end
    end

    // Sample RAM write port; contents survive reset.
    always_ff @(posedge SYS_CLK) begin
        if (wr_en && !RESET) begin
            mem[wp] <= {A2DA_DATA, A2DB_DATA};
        end
    end

    // Capture sequencing: arm, pre-fill, wait for trigger, post-fill, readout.
    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            pre_q     <= '0;
            wp        <= '0;
            cnt       <= '0;
            post      <= '0;
            rd_cnt    <= '0;
            TRIG_ADDR <= '0;
        end else begin
            if (wr_en) begin
                wp <= wp + addr_t'(1);
            end
            case (state)
                S_IDLE: begin
                    if (ARM) begin
                        pre_q  <= PRE_SAMPLES;
                        wp     <= '0;
                        cnt    <= '0;
                        rd_cnt <= '0;
                        state  <= (PRE_SAMPLES == '0) ? S_WAIT : S_PRE;
                    end
                end
                S_PRE: begin
                    cnt <= cnt_nxt;
                    if (cnt_nxt == pre_q) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (trig_hit || FORCE_TRIG) begin
                        TRIG_ADDR <= wp;
                        post      <= post_init;
                        state     <= (post_init == '0) ? S_READ : S_POST;
                    end
                end
                S_POST: begin
                    post <= post - addr_t'(1);
                    if (post == addr_t'(1)) begin
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    if (rd_accept) begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                    if (RD_VALID && RD_LAST) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Registered read port; RD_DATA holds between accepted requests.
    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            RD_DATA  <= '0;
            RD_VALID <= 1'b0;
            RD_LAST  <= 1'b0;
        end else if (rd_accept) begin
            RD_DATA  <= mem[rd_addr];
            RD_VALID <= 1'b1;
            RD_LAST  <= (rd_cnt == LAST_IDX);
        end else begin
            RD_VALID <= 1'b0;
            RD_LAST  <= 1'b0;
        end
    end

    assign STATE = state;

endmodule
